// File: rtl/layer_fwd_engine.sv
// layer_fwd_engine: forward pass of one fully-connected layer.
// Streams INPUTS weights plus one bias per output from a synchronous weight RAM,
// multiplies each weight by the latched input, accumulates with saturation and
// applies the selected activation before storing each output.
module layer_fwd_engine #(
  parameter int INT_W          = 9,
  parameter int FRAC_W         = 8,
  parameter int INPUTS         = 3,
  parameter int OUTPUTS        = 2,
  parameter int RAM_ADDR_W     = 8,
  parameter int RAM_ADDR_START = 0,
  parameter int RAM_DELAY      = 1,
  parameter int ACT_MODE       = 0,
  localparam int NUM_W         = INT_W + FRAC_W
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      enable,
  input  logic                      start_f,
  input  logic                      ready_in,
  input  logic [INPUTS*NUM_W-1:0]   inputs_f,
  output logic [RAM_ADDR_W-1:0]     ram_addr_read,
  input  logic [NUM_W-1:0]          ram_data_read,
  output logic [OUTPUTS*NUM_W-1:0]  outputs_f,
  output logic                      ready_out,
  output logic                      sat_flag
);

  localparam int N_READS = OUTPUTS * (INPUTS + 1);
  localparam int K_W     = $clog2(N_READS + 1);
  localparam int O_W     = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
  localparam int J_W     = $clog2(INPUTS + 1);

  localparam logic [K_W-1:0]          K_LAST     = K_W'(N_READS - 1);
  localparam logic [J_W-1:0]          J_BIAS     = J_W'(INPUTS);
  localparam logic [RAM_ADDR_W-1:0]   ADDR_FIRST = RAM_ADDR_W'(RAM_ADDR_START);
  localparam logic signed [NUM_W-1:0] SAT_MAX    = {1'b0, {(NUM_W-1){1'b1}}};
  localparam logic signed [NUM_W-1:0] SAT_MIN    = {1'b1, {(NUM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_IN = 2'd1,
    S_RUN     = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   load_run;
  logic   issue;
  logic   pipe_busy;

  // Read sequencing: k counts reads, (o, j) name the element being fetched.
  logic [K_W-1:0] k_cnt;
  logic [O_W-1:0] o_cnt;
  logic [J_W-1:0] j_cnt;

  // Tag pipeline, one stage per cycle of RAM latency.
  logic [RAM_DELAY-1:0] tag_v;
  logic [O_W-1:0]       tag_o [RAM_DELAY];
  logic [J_W-1:0]       tag_j [RAM_DELAY];

  // Latched inputs, accumulator and stored results.
  logic signed [NUM_W-1:0] in_lat [INPUTS];
  logic signed [NUM_W-1:0] acc;
  logic signed [NUM_W-1:0] out_r  [OUTPUTS];

  // Datapath for the datum returning this cycle.
  logic                      d_v;
  logic [O_W-1:0]            d_o;
  logic [J_W-1:0]            d_j;
  logic                      is_bias;
  logic signed [NUM_W-1:0]   x_sel;
  logic signed [2*NUM_W-1:0] w_ext;
  logic signed [2*NUM_W-1:0] x_ext;
  logic signed [2*NUM_W-1:0] prod_full;
  logic signed [2*NUM_W-1:0] prod_shr;
  logic                      prod_ovf;
  logic signed [NUM_W-1:0]   prod_sat;
  logic signed [NUM_W-1:0]   p_val;
  logic                      p_clamp;
  logic [NUM_W:0]            sum_ext;
  logic                      sum_ovf;
  logic signed [NUM_W-1:0]   sum_sat;
  logic signed [NUM_W-1:0]   act_val;

  function automatic logic signed [NUM_W-1:0] act_fn(input logic signed [NUM_W-1:0] v);
    if (ACT_MODE == 1) begin
      return v[NUM_W-1] ? SAT_MAX & '0 : v;
    end else if (ACT_MODE == 2) begin
      return v[NUM_W-1] ? (v >>> 3) : v;
    end
    return v;
  endfunction

  assign issue     = (state == S_RUN);
  assign pipe_busy = |tag_v;
  assign ready_out = (state == S_IDLE);

  // State register; enable low freezes the whole pass.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= S_IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  // Next-state logic; load_run marks the edge that enters RUN.
  always_comb begin
    state_nxt = state;
    load_run  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_f) begin
          if (ready_in) begin
            state_nxt = S_RUN;
            load_run  = 1'b1;
          end else begin
            state_nxt = S_WAIT_IN;
          end
        end
      end
      S_WAIT_IN: begin
        if (ready_in) begin
          state_nxt = S_RUN;
          load_run  = 1'b1;
        end
      end
      S_RUN: begin
        if (k_cnt == K_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pipe_busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address generator walking weights then bias for each output in turn.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ram_addr_read <= ADDR_FIRST;
      k_cnt         <= '0;
      o_cnt         <= '0;
      j_cnt         <= '0;
    end else if (enable) begin
      if (load_run) begin
        ram_addr_read <= ADDR_FIRST;
        k_cnt         <= '0;
        o_cnt         <= '0;
        j_cnt         <= '0;
      end else if (issue) begin
        ram_addr_read <= ram_addr_read + RAM_ADDR_W'(1);
        k_cnt         <= k_cnt + K_W'(1);
        if (j_cnt == J_BIAS) begin
          j_cnt <= '0;
          o_cnt <= o_cnt + O_W'(1);
        end else begin
          j_cnt <= j_cnt + J_W'(1);
        end
      end
    end
  end

  // Tag pipeline pairing each returning RAM word with the (o, j) it was read for.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tag_v <= '0;
      for (int i = 0; i < RAM_DELAY; i++) begin
        tag_o[i] <= '0;
        tag_j[i] <= '0;
      end
    end else if (enable) begin
      tag_v[0] <= issue;
      tag_o[0] <= o_cnt;
      tag_j[0] <= j_cnt;
      for (int i = 1; i < RAM_DELAY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
        tag_j[i] <= tag_j[i-1];
      end
    end
  end

  // Input snapshot taken on RUN entry so upstream may move on during the pass.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < INPUTS; i++) in_lat[i] <= '0;
    end else if (enable && load_run) begin
      for (int i = 0; i < INPUTS; i++) in_lat[i] <= inputs_f[i*NUM_W +: NUM_W];
    end
  end

  assign d_v     = tag_v[RAM_DELAY-1];
  assign d_o     = tag_o[RAM_DELAY-1];
  assign d_j     = tag_j[RAM_DELAY-1];
  assign is_bias = (d_j == J_BIAS);

  // Select the latched input that matches the returning weight.
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (d_j == J_W'(i)) x_sel = in_lat[i];
    end
  end

  // Full-width product, rescaled and clamped back to NUM_W; the sum is
  // formed one bit wider so overflow shows up as disagreeing top bits.
  assign w_ext     = {{NUM_W{ram_data_read[NUM_W-1]}}, ram_data_read};
  assign x_ext     = {{NUM_W{x_sel[NUM_W-1]}}, x_sel};
  assign prod_full = w_ext * x_ext;
  assign prod_shr  = prod_full >>> FRAC_W;
  assign prod_ovf  = !((&prod_shr[2*NUM_W-1:NUM_W-1]) || !(|prod_shr[2*NUM_W-1:NUM_W-1]));
  assign prod_sat  = prod_ovf ? (prod_shr[2*NUM_W-1] ? SAT_MIN : SAT_MAX)
                              : prod_shr[NUM_W-1:0];
  assign p_val     = is_bias ? ram_data_read : prod_sat;
  assign p_clamp   = !is_bias && prod_ovf;
  assign sum_ext   = {acc[NUM_W-1], acc} + {p_val[NUM_W-1], p_val};
  assign sum_ovf   = sum_ext[NUM_W] ^ sum_ext[NUM_W-1];
  assign sum_sat   = sum_ovf ? (sum_ext[NUM_W] ? SAT_MIN : SAT_MAX)
                             : sum_ext[NUM_W-1:0];
  assign act_val   = act_fn(sum_sat);

  // Accumulate each returning datum; a bias closes the output and restarts acc.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc      <= '0;
      sat_flag <= 1'b0;
      for (int i = 0; i < OUTPUTS; i++) out_r[i] <= '0;
    end else if (enable) begin
      if (load_run) begin
        acc      <= '0;
        sat_flag <= 1'b0;
      end else if (d_v) begin
        if (p_clamp || sum_ovf) sat_flag <= 1'b1;
        if (is_bias) begin
          acc <= '0;
          for (int i = 0; i < OUTPUTS; i++) begin
            if (d_o == O_W'(i)) out_r[i] <= act_val;
          end
        end else begin
          acc <= sum_sat;
        end
      end
    end
  end

  // Pack stored results onto the output bus, element 0 in the low bits.
  always_comb begin
    outputs_f = '0;
    for (int i = 0; i < OUTPUTS; i++) outputs_f[i*NUM_W +: NUM_W] = out_r[i];
  end

endmodule

// File: tb/tb_layer_fwd_engine.sv
// tb_layer_fwd_engine: four engines share one stimulus stream and one weight
// memory: identity, ReLU and leaky activations at RAM_DELAY=1, and identity at
// RAM_DELAY=3. Expected results are queued per engine when a pass is launched
// and popped by a monitor whenever that engine's ready_out rises.
module tb_layer_fwd_engine;

  localparam int NUM_W = 17;
  localparam int NU    = 4;

  localparam logic [3*NUM_W-1:0] BASIC_IN = {17'h00280, 17'h00180, 17'h00080};
  localparam logic [3*NUM_W-1:0] SAT_IN   = {17'h0FF00, 17'h0FF00, 17'h0FF00};
  localparam logic [3*NUM_W-1:0] JUNK_IN  = {17'h1F000, 17'h0A000, 17'h15500};

  typedef struct packed {
    logic [2*NUM_W-1:0] outs;
    logic               sat;
  } exp_t;

  logic clk = 1'b0;
  logic nreset;
  logic enable;
  logic start_f;
  logic ready_in;
  logic [3*NUM_W-1:0] inputs_f;

  logic [7:0]         addr_id, addr_relu, addr_leaky, addr_d3;
  logic [NUM_W-1:0]   rd_id, rd_relu, rd_leaky;
  logic [NUM_W-1:0]   d3_s0, d3_s1, d3_s2;
  logic [2*NUM_W-1:0] out_id, out_relu, out_leaky, out_d3;
  logic               rdy_id, rdy_relu, rdy_leaky, rdy_d3;
  logic               sat_id, sat_relu, sat_leaky, sat_d3;

  logic [NU-1:0]      rdy;
  logic [NU-1:0]      sat;
  logic [2*NUM_W-1:0] outs [NU];

  logic [NUM_W-1:0] ram_mem [256];
  exp_t             sb_q [NU][$];
  exp_t             mon_e;
  logic [NU-1:0]    rdy_prev = '1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rdy     = {rdy_d3, rdy_leaky, rdy_relu, rdy_id};
  assign sat     = {sat_d3, sat_leaky, sat_relu, sat_id};
  assign outs[0] = out_id;
  assign outs[1] = out_relu;
  assign outs[2] = out_leaky;
  assign outs[3] = out_d3;

  layer_fwd_engine #(.ACT_MODE(0), .RAM_DELAY(1)) u_id (
    .clk(clk), .nreset(nreset), .enable(enable), .start_f(start_f), .ready_in(ready_in),
    .inputs_f(inputs_f), .ram_addr_read(addr_id), .ram_data_read(rd_id),
    .outputs_f(out_id), .ready_out(rdy_id), .sat_flag(sat_id));

  layer_fwd_engine #(.ACT_MODE(1), .RAM_DELAY(1)) u_relu (
    .clk(clk), .nreset(nreset), .enable(enable), .start_f(start_f), .ready_in(ready_in),
    .inputs_f(inputs_f), .ram_addr_read(addr_relu), .ram_data_read(rd_relu),
    .outputs_f(out_relu), .ready_out(rdy_relu), .sat_flag(sat_relu));

  layer_fwd_engine #(.ACT_MODE(2), .RAM_DELAY(1)) u_leaky (
    .clk(clk), .nreset(nreset), .enable(enable), .start_f(start_f), .ready_in(ready_in),
    .inputs_f(inputs_f), .ram_addr_read(addr_leaky), .ram_data_read(rd_leaky),
    .outputs_f(out_leaky), .ready_out(rdy_leaky), .sat_flag(sat_leaky));

  layer_fwd_engine #(.ACT_MODE(0), .RAM_DELAY(3)) u_d3 (
    .clk(clk), .nreset(nreset), .enable(enable), .start_f(start_f), .ready_in(ready_in),
    .inputs_f(inputs_f), .ram_addr_read(addr_d3), .ram_data_read(d3_s2),
    .outputs_f(out_d3), .ready_out(rdy_d3), .sat_flag(sat_d3));

  // Weight RAM read ports, stalled by the same enable as the engines.
  always @(posedge clk) begin
    if (enable) begin
      rd_id    <= ram_mem[addr_id];
      rd_relu  <= ram_mem[addr_relu];
      rd_leaky <= ram_mem[addr_leaky];
      d3_s0    <= ram_mem[addr_d3];
      d3_s1    <= d3_s0;
      d3_s2    <= d3_s1;
    end
  end

  // Monitor: each rising ready_out retires the oldest expected result of that engine.
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (nreset && rdy[u] && !rdy_prev[u]) begin
        if (sb_q[u].size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sb_unexpected unit%0d: got outs=%h, want no result", u, outs[u]);
        end else begin
          mon_e = sb_q[u].pop_front();
          total++;
          if (outs[u] !== mon_e.outs) begin
            bad++;
            $display("[TB] FAIL sb_outputs unit%0d: got %h, want %h", u, outs[u], mon_e.outs);
          end
          total++;
          if (sat[u] !== mon_e.sat) begin
            bad++;
            $display("[TB] FAIL sb_sat unit%0d: got %b, want %b", u, sat[u], mon_e.sat);
          end
        end
      end
    end
    rdy_prev = rdy;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic expectUnit(input int u, input logic [NUM_W-1:0] o0, input logic [NUM_W-1:0] o1,
                            input logic s);
    exp_t e;
    e.outs = {o1, o0};
    e.sat  = s;
    sb_q[u].push_back(e);
  endtask

  task automatic loadRam(input int kind);
    for (int k = 0; k < 8; k++) begin
      case (kind)
        0:       ram_mem[k] = NUM_W'(k) << 7;
        1:       ram_mem[k] = 17'h0FF00;
        2:       ram_mem[k] = 17'h10100;
        default: ram_mem[k] = ((k % 4) == 3) ? 17'h1FE00 : 17'h00000;
      endcase
    end
  endtask

  // One pass: start_f in cycle 0, ready_in held low for wait_cyc cycles,
  // enable low for stall_len cycles from stall_at, inputs_f scrambled after
  // RUN entry; then the cycle each engine raises ready_out is checked.
  task automatic applyStimulus(input int wait_cyc, input int stall_at, input int stall_len,
                               input int lat_fast, input int lat_d3);
    int  lat [NU];
    int  cyc;
    logic done;
    for (int u = 0; u < NU; u++) lat[u] = -1;
    @(posedge clk); #1;
    cyc      = 0;
    start_f  = 1'b1;
    ready_in = (wait_cyc == 0);
    enable   = 1'b1;
    done     = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start_f  = 1'b0;
      ready_in = (cyc >= wait_cyc);
      enable   = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      if (cyc == wait_cyc + 1) inputs_f = JUNK_IN;
      done = 1'b1;
      for (int u = 0; u < NU; u++) begin
        if (lat[u] < 0 && rdy[u]) lat[u] = cyc;
        if (lat[u] < 0) done = 1'b0;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL pass_timeout: got no ready_out after %0d cycles, want completion", cyc);
    end
    for (int u = 0; u < NU - 1; u++) checkOutput("latency_d1", 64'(lat[u]), 64'(lat_fast));
    checkOutput("latency_d3", 64'(lat[NU-1]), 64'(lat_d3));
    start_f  = 1'b0;
    ready_in = 1'b0;
    enable   = 1'b1;
    @(negedge clk); #1;
  endtask

  // Watchdog so a wedged design still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no end of test, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nreset   = 1'b1;
    enable   = 1'b1;
    start_f  = 1'b0;
    ready_in = 1'b0;
    inputs_f = BASIC_IN;
    loadRam(0);
    #1 nreset = 1'b0;
    #2;
    checkOutput("reset_ready", 64'(rdy), 64'hF);
    for (int u = 0; u < NU; u++) checkOutput("reset_outputs", 64'(outs[u]), 64'h0);
    checkOutput("reset_sat", 64'(sat), 64'h0);
    checkOutput("reset_addr", 64'(addr_id), 64'h0);
    #9 nreset = 1'b1;

    $display("[TB] basic pass");
    loadRam(0);
    inputs_f = BASIC_IN;
    for (int u = 0; u < NU; u++) expectUnit(u, 17'h004C0, 17'h00FC0, 1'b0);
    applyStimulus(0, 0, 0, 11, 13);

    $display("[TB] positive saturation");
    loadRam(1);
    inputs_f = SAT_IN;
    for (int u = 0; u < NU; u++) expectUnit(u, 17'h0FFFF, 17'h0FFFF, 1'b1);
    applyStimulus(0, 0, 0, 11, 13);

    $display("[TB] activation on -2.0");
    loadRam(3);
    inputs_f = BASIC_IN;
    expectUnit(0, 17'h1FE00, 17'h1FE00, 1'b0);
    expectUnit(1, 17'h00000, 17'h00000, 1'b0);
    expectUnit(2, 17'h1FFC0, 17'h1FFC0, 1'b0);
    expectUnit(3, 17'h1FE00, 17'h1FE00, 1'b0);
    applyStimulus(0, 0, 0, 11, 13);

    $display("[TB] negative saturation");
    loadRam(2);
    inputs_f = SAT_IN;
    expectUnit(0, 17'h10000, 17'h10000, 1'b1);
    expectUnit(1, 17'h00000, 17'h00000, 1'b1);
    expectUnit(2, 17'h1E000, 17'h1E000, 1'b1);
    expectUnit(3, 17'h10000, 17'h10000, 1'b1);
    applyStimulus(0, 0, 0, 11, 13);

    $display("[TB] handshake with late ready_in");
    loadRam(0);
    inputs_f = BASIC_IN;
    for (int u = 0; u < NU; u++) expectUnit(u, 17'h004C0, 17'h00FC0, 1'b0);
    applyStimulus(5, 0, 0, 16, 18);

    $display("[TB] enable stall mid-run");
    inputs_f = BASIC_IN;
    for (int u = 0; u < NU; u++) expectUnit(u, 17'h004C0, 17'h00FC0, 1'b0);
    applyStimulus(0, 3, 4, 15, 17);

    $display("[TB] reset in cycle 5 of a pass");
    inputs_f = BASIC_IN;
    @(posedge clk); #1;
    start_f  = 1'b1;
    ready_in = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start_f = 1'b0;
    end
    checkOutput("abort_busy", 64'(rdy), 64'h0);
    nreset = 1'b0;
    #1;
    checkOutput("abort_ready", 64'(rdy), 64'hF);
    for (int u = 0; u < NU; u++) checkOutput("abort_outputs", 64'(outs[u]), 64'h0);
    checkOutput("abort_sat", 64'(sat), 64'h0);
    checkOutput("abort_addr_d1", 64'(addr_id), 64'h0);
    checkOutput("abort_addr_d3", 64'(addr_d3), 64'h0);
    @(negedge clk);
    @(posedge clk); #1;
    nreset   = 1'b1;
    ready_in = 1'b0;

    $display("[TB] pass after reset");
    inputs_f = BASIC_IN;
    for (int u = 0; u < NU; u++) expectUnit(u, 17'h004C0, 17'h00FC0, 1'b0);
    applyStimulus(0, 0, 0, 11, 13);

    repeat (3) @(posedge clk);
    for (int u = 0; u < NU; u++) checkOutput("sb_drained", 64'(sb_q[u].size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
